// File: rtl/tib_loader.sv
// Console line loader: edits an incoming byte stream and writes the line into TIB for eJ32.
// Latency: an accepted byte produces its registered write in the next cycle; the terminator follows a line end by one cycle.
// Backpressure: rx_ready drops from line end until ack_i re-arms the loader; one byte per cycle otherwise.
module tib_loader #(
    parameter int TIB    = 'h1000,
    parameter int TIB_SZ = 'h100,
    parameter int ASZ    = 17,
    localparam int PW    = $clog2(TIB_SZ)
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           rx_valid,
    input  logic [7:0]     rx_data,
    output logic           rx_ready,
    output logic [ASZ-1:0] addr_o,
    output logic [7:0]     data_o,
    output logic           we_o,
    output logic           busy_o,
    output logic           line_rdy_o,
    output logic [PW-1:0]  len_o,
    output logic           ovf_o,
    input  logic           ack_i
);

    typedef enum logic [1:0] {IDLE, RECV, TERM, WAIT} state_t;

    localparam logic [PW-1:0] PTR_MAX = PW'(TIB_SZ - 1);

    state_t        state;
    logic [PW-1:0] ptr;
    logic          inc;
    logic [PW-1:0] ptr_eff;
    logic [7:0]    ch;
    logic          is_eol;
    logic          is_bs;
    logic          is_print;

    // ptr itself advances one edge after the write is issued, so decisions for
    // a byte arriving back-to-back must use the pointer including that pending step.
    always_comb begin
        ptr_eff  = ptr + PW'(inc);
        ch       = (rx_data == 8'h09) ? 8'h20 : rx_data;
        is_eol   = (rx_data == 8'h0D) || (rx_data == 8'h0A);
        is_bs    = (rx_data == 8'h08) || (rx_data == 8'h7F);
        is_print = (ch >= 8'h20) && !is_bs;
    end

    function automatic logic [ASZ-1:0] tib_addr(input logic [PW-1:0] p);
        return ASZ'(TIB) + ASZ'(p);
    endfunction

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= IDLE;
            ptr        <= '0;
            inc        <= 1'b0;
            rx_ready   <= 1'b1;
            we_o       <= 1'b0;
            addr_o     <= ASZ'(TIB);
            data_o     <= 8'h00;
            busy_o     <= 1'b0;
            line_rdy_o <= 1'b0;
            len_o      <= '0;
            ovf_o      <= 1'b0;
        end else begin
            we_o <= 1'b0;
            inc  <= 1'b0;
            ptr  <= ptr_eff;
            case (state)
                IDLE, RECV: begin
                    if (rx_valid && rx_ready) begin
                        busy_o <= 1'b1;
                        state  <= RECV;
                        if (is_eol) begin
                            state    <= TERM;
                            rx_ready <= 1'b0;
                            we_o     <= 1'b1;
                            addr_o   <= tib_addr(ptr_eff);
                            data_o   <= 8'h00;
                        end else if (is_bs) begin
                            if (ptr_eff != '0)
                                ptr <= ptr_eff - 1'b1;
                        end else if (is_print) begin
                            if (ptr_eff < PTR_MAX) begin
                                we_o   <= 1'b1;
                                addr_o <= tib_addr(ptr_eff);
                                data_o <= ch;
                                inc    <= 1'b1;
                            end else begin
                                ovf_o <= 1'b1;
                            end
                        end
                    end
                end
                TERM: begin
                    len_o      <= ptr;
                    line_rdy_o <= 1'b1;
                    busy_o     <= 1'b0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (ack_i) begin
                        line_rdy_o <= 1'b0;
                        ovf_o      <= 1'b0;
                        ptr        <= '0;
                        addr_o     <= ASZ'(TIB);
                        rx_ready   <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tib_loader.sv
// Randomized and directed bench for tib_loader against a line-editing reference model.
module tb_tib_loader;
    localparam int TIB    = 'h1000;
    localparam int TIB_SZ = 'h100;
    localparam int ASZ    = 17;
    localparam int PW     = 8;

    logic           clk = 1'b0;
    logic           clr = 1'b1;
    logic           rx_valid = 1'b0;
    logic [7:0]     rx_data = 8'h00;
    logic           rx_ready;
    logic [ASZ-1:0] addr_o;
    logic [7:0]     data_o;
    logic           we_o;
    logic           busy_o;
    logic           line_rdy_o;
    logic [PW-1:0]  len_o;
    logic           ovf_o;
    logic           ack_i = 1'b0;

    tib_loader #(.TIB(TIB), .TIB_SZ(TIB_SZ), .ASZ(ASZ)) dut (
        .clk(clk), .clr(clr), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .addr_o(addr_o), .data_o(data_o), .we_o(we_o), .busy_o(busy_o),
        .line_rdy_o(line_rdy_o), .len_o(len_o), .ovf_o(ovf_o), .ack_i(ack_i)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every write strobe seen on the memory port, as {addr, data}.
    logic [24:0] wr_q[$];
    always @(negedge clk)
        if (clr === 1'b0 && we_o === 1'b1)
            wr_q.push_back({addr_o, data_o});

    logic [7:0]  line_q[$];
    logic [24:0] exp_w[$];
    int          exp_len;
    logic        exp_ovf;

    // Reference: replay the line-editing rules on a plain integer cursor.
    task automatic model();
        int p;
        logic [7:0] b;
        p = 0;
        exp_w.delete();
        exp_ovf = 1'b0;
        exp_len = 0;
        foreach (line_q[i]) begin
            b = line_q[i];
            if (b == 8'h0D || b == 8'h0A) begin
                exp_w.push_back({17'(TIB + p), 8'h00});
                exp_len = p;
                return;
            end
            if (b == 8'h08 || b == 8'h7F) begin
                if (p > 0) p--;
                continue;
            end
            if (b == 8'h09) b = 8'h20;
            if (b < 8'h20) continue;
            if (p < TIB_SZ - 1) begin
                exp_w.push_back({17'(TIB + p), b});
                p++;
            end else begin
                exp_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rx_ready"}, 32'(rx_ready), 1);
        check({tag, "_we"}, 32'(we_o), 0);
        check({tag, "_addr"}, 32'(addr_o), TIB);
        check({tag, "_data"}, 32'(data_o), 0);
        check({tag, "_busy"}, 32'(busy_o), 0);
        check({tag, "_line_rdy"}, 32'(line_rdy_o), 0);
        check({tag, "_len"}, 32'(len_o), 0);
        check({tag, "_ovf"}, 32'(ovf_o), 0);
    endtask

    task automatic send_line(input int gap_pct);
        int n;
        n = 0;
        foreach (line_q[i]) begin
            @(negedge clk);
            if (n == 1) check("busy_after_first", 32'(busy_o), 1);
            while ($urandom_range(99) < gap_pct) begin
                rx_valid = 1'b0;
                @(negedge clk);
            end
            rx_valid = 1'b1;
            rx_data  = line_q[i];
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        if (n == 1) check("busy_after_first", 32'(busy_o), 1);
    endtask

    task automatic run_line(input string tag, input int gap_pct, input bit hold_wait, input bit early_ack);
        int t;
        int nw;
        wr_q.delete();
        model();
        if (early_ack) ack_i = 1'b1;
        send_line(gap_pct);
        t = 0;
        while (line_rdy_o !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        #1;
        check({tag, "_line_rdy"}, 32'(line_rdy_o), 1);
        check({tag, "_busy_wait"}, 32'(busy_o), 0);
        check({tag, "_len"}, 32'(len_o), 32'(exp_len));
        check({tag, "_ovf"}, 32'(ovf_o), 32'(exp_ovf));
        check({tag, "_nwrites"}, 32'(wr_q.size()), 32'(exp_w.size()));
        nw = (wr_q.size() < exp_w.size()) ? wr_q.size() : exp_w.size();
        for (int i = 0; i < nw; i++)
            check({tag, "_wr"}, 32'(wr_q[i]), 32'(exp_w[i]));
        if (hold_wait) begin
            rx_valid = 1'b1;
            rx_data  = 8'h41;
            repeat (8) begin
                @(negedge clk);
                check({tag, "_wait_rx_ready"}, 32'(rx_ready), 0);
            end
            check({tag, "_wait_nwrites"}, 32'(wr_q.size()), 32'(exp_w.size()));
            rx_valid = 1'b0;
        end
        ack_i = 1'b1;
        @(negedge clk);
        ack_i = 1'b0;
        check({tag, "_ack_line_rdy"}, 32'(line_rdy_o), 0);
        check({tag, "_ack_ovf"}, 32'(ovf_o), 0);
        check({tag, "_ack_rx_ready"}, 32'(rx_ready), 1);
    endtask

    task automatic put_str(input string s);
        for (int i = 0; i < s.len(); i++) line_q.push_back(s[i]);
    endtask

    function automatic logic [7:0] rand_byte();
        int k;
        logic [7:0] c;
        k = $urandom_range(99);
        if (k < 60) return 8'($urandom_range(8'h20, 8'h7E));
        if (k < 68) return 8'h08;
        if (k < 72) return 8'h7F;
        if (k < 80) return 8'h09;
        c = 8'($urandom_range(0, 31));
        if (c == 8'h0D || c == 8'h0A || c == 8'h08 || c == 8'h09) c = 8'h1B;
        return c;
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        check_reset("rst_held");
        clr = 1'b0;
        @(negedge clk);
        check_reset("rst_rel");

        line_q.delete(); put_str("1 2 +"); line_q.push_back(8'h0D);
        run_line("calc", 0, 1'b0, 1'b0);

        line_q.delete(); put_str("ab"); line_q.push_back(8'h08); put_str("c"); line_q.push_back(8'h0A);
        run_line("bs", 0, 1'b0, 1'b0);

        line_q.delete(); repeat (3) line_q.push_back(8'h08); put_str("x"); line_q.push_back(8'h0D);
        run_line("bs_sat", 0, 1'b0, 1'b0);

        line_q.delete(); repeat (300) line_q.push_back(8'h41); line_q.push_back(8'h0D);
        run_line("ovf", 0, 1'b0, 1'b0);

        line_q.delete(); put_str("hi"); line_q.push_back(8'h0D);
        run_line("hold", 0, 1'b1, 1'b0);

        line_q.delete(); line_q.push_back(8'h0D);
        run_line("empty", 0, 1'b0, 1'b1);

        // Abandon a line mid-flight: outputs must drop to reset values immediately.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = 8'h61 + 8'(i);
            @(posedge clk);
        end
        #2;
        clr      = 1'b1;
        rx_valid = 1'b0;
        #1;
        check_reset("clr_mid");
        @(negedge clk);
        clr = 1'b0;
        line_q.delete(); put_str("x"); line_q.push_back(8'h0D);
        run_line("after_clr", 0, 1'b0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            int len;
            line_q.delete();
            len = (n % 10 == 9) ? $urandom_range(240, 300) : $urandom_range(0, 30);
            for (int i = 0; i < len; i++) line_q.push_back(rand_byte());
            line_q.push_back(($urandom_range(1) == 1) ? 8'h0D : 8'h0A);
            run_line("rand", (n % 3 == 0) ? 30 : 0, 1'b0, (n % 7 == 3));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
